// File: rtl/handshake_arb_fifo.sv
// Round-robin merge of CHANNELS valid/ready producers into one consumer through a
// DEPTH-entry FIFO; every queued word carries the index of the channel it came from.
module handshake_arb_fifo #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 2,
   parameter int DEPTH    = 4,
   localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       in_valid_i,
   input  logic [CHANNELS*WIDTH-1:0] in_data_i,
   output logic [CHANNELS-1:0]       in_ready_o,
   output logic                      out_valid_o,
   output logic [WIDTH-1:0]          out_data_o,
   output logic [CW-1:0]             out_chan_o,
   input  logic                      out_ready_i,
   output logic [AW:0]               count_o
);

   logic [CW+WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]       wrPtr_q, wrPtr_d;
   logic [AW-1:0]       rdPtr_q, rdPtr_d;
   logic [AW:0]         count_q, count_d;
   logic [CW-1:0]       lastGrant_q, lastGrant_d;

   logic                grantFound;
   logic [CW-1:0]       grant;
   int                  candIdx;
   logic                full;
   logic                push;
   logic                pop;
   logic [WIDTH-1:0]    pushData;
   logic [CW+WIDTH-1:0] headWord;

   assign full        = (count_q == (AW+1)'(DEPTH));
   assign out_valid_o = (count_q != '0);
   assign pop         = out_valid_o & out_ready_i;
   assign headWord    = mem_q[rdPtr_q];
   assign out_data_o  = out_valid_o ? headWord[WIDTH-1:0] : '0;
   assign out_chan_o  = out_valid_o ? headWord[CW+WIDTH-1:WIDTH] : '0;
   assign count_o     = count_q;

   // Search for the first requester after the last granted channel, wrapping round.
   always_comb begin
      grantFound = 1'b0;
      grant      = '0;
      candIdx    = 0;
      for (int k = 1; k <= CHANNELS; k++) begin
         candIdx = (int'(lastGrant_q) + k) % CHANNELS;
         if (!grantFound && in_valid_i[candIdx]) begin
            grantFound = 1'b1;
            grant      = CW'(candIdx);
         end
      end
   end

   // Only the winning channel sees ready, and only when a slot is free right now.
   always_comb begin
      in_ready_o = '0;
      push       = grantFound && !full && !rst;
      pushData   = in_data_i[int'(grant)*WIDTH +: WIDTH];
      if (push) begin
         in_ready_o[grant] = 1'b1;
      end
   end

   always_comb begin
      wrPtr_d     = wrPtr_q;
      rdPtr_d     = rdPtr_q;
      count_d     = count_q;
      lastGrant_d = lastGrant_q;
      if (push) begin
         wrPtr_d     = wrPtr_q + AW'(1);
         lastGrant_d = grant;
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         lastGrant_q <= CW'(CHANNELS - 1);
      end else begin
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
         lastGrant_q <= lastGrant_d;
      end
   end

   // Storage is deliberately left unreset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wrPtr_q] <= {grant, pushData};
      end
   end

endmodule

// File: tb/tb_handshake_arb_fifo.sv
// Directed bench for handshake_arb_fifo at WIDTH=32, CHANNELS=2, DEPTH=4:
// reset, round-robin order, full/empty limits, push+pop, wrap and mid-run reset.
module tb_handshake_arb_fifo;

   logic        clk;
   logic        rst;
   logic [1:0]  inValid;
   logic [63:0] inData;
   logic [1:0]  inReady;
   logic        outValid;
   logic [31:0] outData;
   logic [0:0]  outChan;
   logic        outReady;
   logic [2:0]  count;

   int checkCount;
   int errorCount;

   handshake_arb_fifo #(.WIDTH(32), .CHANNELS(2), .DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (inValid),
      .in_data_i   (inData),
      .in_ready_o  (inReady),
      .out_valid_o (outValid),
      .out_data_o  (outData),
      .out_chan_o  (outChan),
      .out_ready_i (outReady),
      .count_o     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case some wait never completes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive inputs one step after the edge and let combinational outputs settle.
   task automatic applyStimulus(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1, input logic ordy);
      inValid  = v;
      inData   = {d1, d0};
      outReady = ordy;
      #1;
   endtask

   task automatic waitEdge();
      @(posedge clk);
      #1;
   endtask

   logic [0:0]  expChan [4];
   logic [31:0] expData [4];

   initial begin
      int a;
      int b;
      int outIdx;
      int sent;
      int rcv;
      int cyc;
      logic [1:0] rdy;

      checkCount = 0;
      errorCount = 0;
      expChan = '{1'b0, 1'b1, 1'b0, 1'b1};
      expData = '{32'hA0, 32'hB0, 32'hA1, 32'hB1};

      // Reset with both producers requesting
      rst = 1'b1;
      applyStimulus(2'b11, 32'hA0, 32'hB0, 1'b0);
      waitEdge();
      waitEdge();
      checkOutput("rst_in_ready", inReady, 2'b00);
      checkOutput("rst_out_valid", outValid, 1'b0);
      checkOutput("rst_count", count, 3'd0);
      checkOutput("rst_out_data", outData, 32'h0);
      rst = 1'b0;
      #1;
      checkOutput("post_rst_in_ready", inReady, 2'b01);

      // Round-robin with both channels always valid
      a = 0;
      b = 0;
      outIdx = 0;
      for (int c = 0; c < 6; c++) begin
         applyStimulus(2'b11, 32'hA0 + a, 32'hB0 + b, 1'b1);
         checkOutput($sformatf("rr_grant%0d", c), inReady, (c % 2 == 0) ? 2'b01 : 2'b10);
         if (outValid && outIdx < 4) begin
            checkOutput($sformatf("rr_chan%0d", outIdx), outChan, expChan[outIdx]);
            checkOutput($sformatf("rr_data%0d", outIdx), outData, expData[outIdx]);
            outIdx++;
         end
         rdy = inReady;
         waitEdge();
         if (rdy[0]) a++;
         if (rdy[1]) b++;
      end
      checkOutput("rr_out_count", outIdx, 4);
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b1);
      waitEdge();
      waitEdge();
      checkOutput("rr_drained", count, 3'd0);

      // Fill to full from channel 0 with the consumer stalled
      for (int i = 0; i < 4; i++) begin
         applyStimulus(2'b01, 32'h10 + i, 32'h0, 1'b0);
         checkOutput($sformatf("fill_ready%0d", i), inReady, 2'b01);
         waitEdge();
      end
      applyStimulus(2'b01, 32'h14, 32'h0, 1'b0);
      checkOutput("full_count", count, 3'd4);
      checkOutput("full_in_ready", inReady, 2'b00);
      checkOutput("full_head", outData, 32'h10);
      applyStimulus(2'b01, 32'h14, 32'h0, 1'b1);
      checkOutput("full_pop_in_ready", inReady, 2'b00);
      waitEdge();
      applyStimulus(2'b01, 32'h14, 32'h0, 1'b0);
      checkOutput("after_pop_in_ready", inReady, 2'b01);
      checkOutput("after_pop_count", count, 3'd3);
      checkOutput("after_pop_head", outData, 32'h11);
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("full_drain%0d", i), outData, 32'h11 + i);
         waitEdge();
      end
      checkOutput("full_drained", count, 3'd0);

      // Simultaneous push and pop at occupancy 2
      applyStimulus(2'b01, 32'h20, 32'h0, 1'b0);
      waitEdge();
      applyStimulus(2'b01, 32'h21, 32'h0, 1'b0);
      waitEdge();
      checkOutput("pp_count_pre", count, 3'd2);
      applyStimulus(2'b01, 32'h22, 32'h0, 1'b1);
      checkOutput("pp_head0", outData, 32'h20);
      waitEdge();
      checkOutput("pp_count1", count, 3'd2);
      applyStimulus(2'b01, 32'h23, 32'h0, 1'b1);
      checkOutput("pp_head1", outData, 32'h21);
      waitEdge();
      checkOutput("pp_count2", count, 3'd2);
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b1);
      checkOutput("pp_head2", outData, 32'h22);
      waitEdge();
      checkOutput("pp_head3", outData, 32'h23);
      waitEdge();
      checkOutput("pp_drained", count, 3'd0);

      // Channel 1 alone with a randomly stalling consumer, crossing the pointer wrap
      sent = 0;
      rcv = 0;
      cyc = 0;
      while (rcv < 10 && cyc < 300) begin
         applyStimulus({sent < 10, 1'b0}, 32'h0, sent, 1'($urandom_range(0, 1)));
         if (outValid && outReady) begin
            checkOutput($sformatf("wrap_data%0d", rcv), outData, rcv);
            checkOutput($sformatf("wrap_chan%0d", rcv), outChan, 1'b1);
            rcv++;
         end
         rdy = inReady;
         waitEdge();
         if (rdy[1]) sent++;
         cyc++;
      end
      checkOutput("wrap_received", rcv, 10);
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b0);
      checkOutput("wrap_empty", count, 3'd0);

      // Pop request on an empty FIFO is ignored
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b1);
      waitEdge();
      checkOutput("empty_pop_count", count, 3'd0);
      checkOutput("empty_out_valid", outValid, 1'b0);

      // Reset in the middle of operation discards queued words
      for (int i = 0; i < 3; i++) begin
         applyStimulus(2'b01, 32'h30 + i, 32'h0, 1'b0);
         waitEdge();
      end
      checkOutput("mid_count_pre", count, 3'd3);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_out_valid", outValid, 1'b0);
      checkOutput("mid_rst_count", count, 3'd0);
      checkOutput("mid_rst_in_ready", inReady, 2'b00);
      waitEdge();
      rst = 1'b0;
      applyStimulus(2'b01, 32'h40, 32'h0, 1'b0);
      checkOutput("mid_post_ready", inReady, 2'b01);
      waitEdge();
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b1);
      checkOutput("mid_post_valid", outValid, 1'b1);
      checkOutput("mid_post_data", outData, 32'h40);
      checkOutput("mid_post_count", count, 3'd1);
      waitEdge();
      checkOutput("mid_final_count", count, 3'd0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
